// File: rtl/sar_pkg.sv
// Shared definitions for the 7-bit successive-approximation controller:
// state encoding, code width, idle DAC code and legal settle range.
package sar_pkg;

  localparam int NBITS      = 7;
  localparam int SETTLE_MIN = 2;
  localparam int SETTLE_MAX = 15;

  typedef logic [NBITS-1:0] code_t;
  typedef logic [2:0]       bit_idx_t;
  typedef logic [3:0]       settle_cnt_t;

  localparam code_t    DAC_IDLE = 7'h7F;
  localparam bit_idx_t MSB_IDX  = 3'(NBITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Trial code: the working code with the bit under test cleared.
  function automatic code_t trial_code(input code_t work, input bit_idx_t idx);
    code_t mask;
    mask = code_t'(1) << idx;
    return work & ~mask;
  endfunction

endpackage

// File: rtl/sar_controller.sv
// SAR conversion sequencer: walks a 7-bit trial code from MSB to LSB, holding
// each trial SETTLE cycles and deciding each bit from the registered comparator.
module sar_controller #(
  parameter int SETTLE = 2,
  parameter int NBITS  = sar_pkg::NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             cmp,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  import sar_pkg::*;

  if (NBITS != sar_pkg::NBITS) begin : g_bad_nbits
    $error("sar_controller: NBITS is fixed at 7");
  end
  if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("sar_controller: SETTLE must be within 2..15");
  end

  localparam settle_cnt_t SETTLE_LAST = settle_cnt_t'(SETTLE - 1);
  localparam code_t       FIRST_TRIAL = trial_code(DAC_IDLE, MSB_IDX);

  state_t      state;
  code_t       work;
  bit_idx_t    idx;
  settle_cnt_t settle_cnt;

  code_t trial;
  code_t decided;
  logic  decide;

  // NOTE: every always_comb output gets a value on every path (here by plain
  // continuous expressions) so no latch can be inferred.
  always_comb begin
    trial   = trial_code(work, idx);
    decided = cmp ? trial : work;
    decide  = (state == CONV) && (settle_cnt == SETTLE_LAST);
  end

  // NOTE: all state and outputs are registered with non-blocking assignments so
  // every read in this block sees the pre-edge value, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      work       <= DAC_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      dac_code   <= DAC_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= CONV;
            busy       <= 1'b1;
            work       <= DAC_IDLE;
            idx        <= MSB_IDX;
            settle_cnt <= '0;
            dac_code   <= FIRST_TRIAL;
          end
        end

        CONV: begin
          if (!decide) begin
            settle_cnt <= settle_cnt + 1'b1;
          end else begin
            settle_cnt <= '0;
            if (idx != '0) begin
              work     <= decided;
              idx      <= idx - 1'b1;
              dac_code <= trial_code(decided, idx - 1'b1);
            end else begin
              // Last bit decided: publish, then either chain or go idle.
              result   <= decided;
              done     <= 1'b1;
              work     <= DAC_IDLE;
              if (cont) begin
                idx      <= MSB_IDX;
                dac_code <= FIRST_TRIAL;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                idx      <= '0;
                dac_code <= DAC_IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_controller.sv
// Self-checking bench for sar_controller: two instances (SETTLE=2 and 3),
// each driven by a registered comparator model of an ideal analog input.
module tb_sar_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cont, cmp = 1'b0;
  logic [6:0] analog;
  logic [6:0] dac_code, result;
  logic       busy, done;

  logic       start3, cont3, cmp3 = 1'b0;
  logic [6:0] analog3;
  logic [6:0] dac3, result3;
  logic       busy3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sar_controller #(.SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .cmp(cmp),
    .dac_code(dac_code), .busy(busy), .done(done), .result(result)
  );

  sar_controller #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cont(cont3), .cmp(cmp3),
    .dac_code(dac3), .busy(busy3), .done(done3), .result(result3)
  );

  // Comparator registered one cycle after the DAC code it compares.
  always @(posedge clk) begin
    cmp  <= (dac_code >= analog);
    cmp3 <= (dac3 >= analog3);
  end

  typedef struct {
    int analog;
    int exp_result;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one conversion on the SETTLE=2 instance and wait (bounded) for done.
  task automatic run_conv(input int a, input int exp_res, input bit trace);
    int n;
    int trials[7];
    trials = '{63, 95, 79, 71, 67, 65, 64};
    analog = 7'(a);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    n = 0;
    while (!done && n < 60) begin
      if (trace && n < 14 && (n % 2) == 0)
        check($sformatf("trial_%0d", n / 2), int'(dac_code), trials[n / 2]);
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 14);
    check($sformatf("result_a%0d", a), int'(result), exp_res);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("dac_idle_after_done", int'(dac_code), 127);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired actual 1 expected 0");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   n, done_cnt, busy_low;
    int   done_at[$];

    vecs[0] = '{0, 0};     vecs[1] = '{127, 127}; vecs[2] = '{1, 1};
    vecs[3] = '{37, 37};   vecs[4] = '{100, 100}; vecs[5] = '{85, 85};
    vecs[6] = '{126, 126}; vecs[7] = '{63, 63};

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; analog = '0;
    start3 = 1'b0; cont3 = 1'b0; analog3 = '0;
    repeat (3) @(negedge clk);
    check("rst_dac", int'(dac_code), 127);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_dac3", int'(dac3), 127);
    rst_n = 1'b1;

    run_conv(64, 64, 1'b1);
    foreach (vecs[i]) run_conv(vecs[i].analog, vecs[i].exp_result, 1'b0);

    for (int a = 0; a < 128; a++) run_conv(a, a, 1'b0);

    // Result holds while idle, even as the analog input moves.
    analog = 7'd5;
    repeat (6) @(negedge clk);
    check("result_held", int'(result), 127);
    check("idle_busy", int'(busy), 0);

    // Continuous mode: three chained conversions, cont dropped during the third.
    analog = 7'd37;
    cont   = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    busy_low = 0;
    for (n = 0; n <= 44; n++) begin
      if (!busy && n < 42) busy_low++;
      if (done) begin
        done_at.push_back(n);
        check("cont_result", int'(result), 37);
        if (n == 28) cont = 1'b0;
      end
      @(negedge clk);
    end
    check("cont_done_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      check("cont_done0", done_at[0], 14);
      check("cont_done1", done_at[1], 28);
      check("cont_done2", done_at[2], 42);
    end
    check("cont_busy_gaps", busy_low, 0);
    check("cont_end_busy", int'(busy), 0);

    // Reset five cycles into a conversion.
    analog = 7'd90;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_dac", int'(dac_code), 127);
    check("midrst_done", int'(done), 0);
    check("midrst_result", int'(result), 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    // First edge after release already accepts start.
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("post_rst_start", int'(busy), 1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_latency", n, 14);
    check("post_rst_result", int'(result), 90);

    // SETTLE=3: start held high throughout; one done at 21 cycles.
    analog3 = 7'd50;
    start3  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    done_cnt = 0;
    while (!done3 && n < 80) begin
      if (n == 2) check("s3_trial0_held", int'(dac3), 63);
      if (n == 3) check("s3_trial1", int'(dac3), 31);
      if (!busy3) busy_low++;
      if (n == 20) start3 = 1'b0;
      @(negedge clk);
      n++;
    end
    check("s3_latency", n, 21);
    check("s3_result", int'(result3), 50);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done3 || busy3) done_cnt++;
    end
    check("s3_stays_idle", done_cnt, 0);
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    check("s3_restart", int'(busy3), 1);
    check("s3_result_kept", int'(result3), 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 Parameter: SETTLE, default 2, number of clock cycles each trial code is held before the comparator result is sampled; legal range 2..15.
REQ-002 Parameter: NBITS, default 7, conversion resolution; fixed at 7 for this block.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 Port: start  input  1  conversion request; sampled only in IDLE.
REQ-006 Port: cont  input  1  continuous mode; when high at conversion end, next conversion starts without IDLE.
REQ-007 Port: cmp  input  1  registered comparator result; 1 = dac_code >= analog input.
REQ-008 Port: dac_code  output  7  trial code driven to the comparator's reference input.
REQ-009 Port: busy  output  1  high while a conversion is in progress.
REQ-010 Port: done  output  1  one-cycle pulse when result is updated.
REQ-011 Port: result  output  7  last completed conversion; held until the next completion.

Function
REQ-012 FSM states SHALL be IDLE and CONV, plus a 3-bit bit index (6..0) and a 4-bit settle counter.
REQ-013 In IDLE, dac_code SHALL be 7'h7F and busy SHALL be 0.
REQ-014 On the edge where start=1 in IDLE (edge E0), the block SHALL enter CONV, set busy=1, load working code 7'h7F, bit index 6, settle counter 0.
REQ-015 In CONV, dac_code SHALL equal working code with the bit at the current index cleared (trial code).
REQ-016 Each trial SHALL be held exactly SETTLE cycles; cmp SHALL be sampled at the edge closing that window.
REQ-017 Decision rule: cmp=1 -> working code takes the trial value (bit cleared); cmp=0 -> bit stays set.
REQ-018 Result SHALL be the smallest code c with c >= analog input, i.e. exact for analog 0..127.
REQ-019 Bit-6 decision at edge E0+SETTLE, bit-k decision at edge E0+(7-k)*SETTLE; total latency 7*SETTLE cycles.
REQ-020 At the bit-0 decision edge, result SHALL load the final code and done SHALL be 1 for exactly the following cycle.
REQ-021 At that edge, cont=0 -> return to IDLE, busy=0; cont=1 -> restart CONV with 7'h7F, index 6, busy stays 1, no idle cycle.
REQ-022 start SHALL be ignored while busy=1; no queuing.
REQ-023 start and cont changes mid-conversion SHALL NOT alter the conversion in progress.
REQ-024 cmp SHALL be ignored on all edges except decision edges.
REQ-025 result SHALL never change except at a decision edge of bit 0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, dac_code=7'h7F, busy=0, done=0, result=7'h00, counters 0.
REQ-027 Reset mid-conversion SHALL abandon the conversion with no done pulse and result unchanged from 7'h00.
REQ-028 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge with rst_n=1.

Structure
REQ-029 Shared package sar_pkg SHALL hold the state enum (IDLE, CONV), NBITS=7, DAC_IDLE=7'h7F and the SETTLE range limits.
REQ-030 The block SHALL be a single module with no sub-module; settle counter and bit index are internal registers.

Verification
REQ-031 Bench SHALL model the comparator as cmp registered one cycle after (dac_code >= analog).
REQ-032 analog=64, SETTLE=2, start pulse -> trial sequence 63,95,79,71,67,65,64; result=64; done 14 cycles after E0.
REQ-033 analog=0 and analog=127 -> result 0 and 127 respectively; all 128 values sweep exact.
REQ-034 cont=1, analog=37 -> back-to-back conversions, busy stays 1, done every 14 cycles, result=37 each time.
REQ-035 rst_n low at cycle 5 of a conversion -> busy=0, dac_code=7'h7F, no done, result=0 immediately.
REQ-036 start held high while busy, SETTLE=3 -> ignored; one done at 21 cycles; next conversion only if start high in IDLE.
